// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags -- single-clock FIFO with fill level, almost-full/almost-empty
// thresholds and sticky overflow/underflow error flags.
//
// Build option: define FIFO_SYNC_FWFT_EN for first-word-fall-through reads
// (head word shown combinationally on rd_data, rd_en acknowledges and pops).
// Without it, reads are registered: rd_data updates at the edge that accepts
// the read and is valid the cycle after rd_en.
//
// Every flag is decoded from the registered level only, so no combinational
// path runs from wr_en/rd_en to any status output.

module fifo_sync_flags #(
   parameter int DEPTH    = 16,  // power of two, >= 2
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 14,  // 1 .. DEPTH
   parameter int AE_LEVEL = 2    // 0 .. DEPTH-1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;

   // Width-matched constants so the level comparisons stay the same width.
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
   localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Storage; deliberately not reset so it can map onto RAM resources.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          overflow_q,  overflow_d;
   logic          underflow_q, underflow_d;

   logic full_w;
   logic empty_w;
   logic wr_acc;   // write accepted this cycle
   logic rd_acc;   // read accepted this cycle

   // Status flags, decoded purely from the registered occupancy.
   always_comb begin
      full_w       = (level_q == LVL_FULL);
      empty_w      = (level_q == '0);
      full         = full_w;
      empty        = empty_w;
      almost_full  = (level_q >= LVL_AF);
      almost_empty = (level_q <= LVL_AE);
      level        = level_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

   // Accept/reject decisions and next-state for pointers, level and errors.
   // Gating by full/empty is what makes simultaneous access at the
   // boundaries degrade to a single accepted operation.
   always_comb begin
      wr_acc   = wr_en & ~full_w;
      rd_acc   = rd_en & ~empty_w;

      wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      level_d  = level_q;
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full_w);
      underflow_d = (underflow_q & ~clr_err) | (rd_en & empty_w);
   end

   // Control state: pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage write port; rejected writes never touch the array.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

`ifdef FIFO_SYNC_FWFT_EN

   // Head word shown directly; meaningless while empty is high.
   always_comb begin
      rd_data = mem_q[rd_ptr_q];
   end

`else

   logic [WIDTH-1:0] rd_data_q;

   // Registered read: capture the head word at the edge that accepts the
   // read, otherwise hold the last word read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_acc) begin
         rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   // Drive the output from the read register.
   always_comb begin
      rd_data = rd_data_q;
   end

`endif

endmodule
